watchdog_supervisor: RTL and testbench

Supervisor that drives the `Watchdog` timer and responds when it expires. It turns a system heartbeat into single-cycle `restart` kicks and gates the watchdog `enable`. On `timeout` it holds a timed system reset, then waits out a holdoff before re-arming. After a configured number of consecutive expiries it escalates to a latched fault. It sits between the system heartbeat source, the `Watchdog` instance, and the system reset tree.

---
 rtl/watchdog_supervisor.sv | 145 ++++++++++++++
 tb/tb_watchdog_supervisor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/watchdog_supervisor.sv
// Watchdog supervisor: converts heartbeats into restart kicks, holds a timed system
// reset on each watchdog expiry, and escalates to a latched fault after repeated expiries.
module watchdog_supervisor #(
    parameter int RST_CYCLES  = 8,
    parameter int HOLDOFF     = 4,
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       heartbeat,
    input  logic       fault_clear,
    input  logic       timeout,
    output logic       wd_enable,
    output logic       wd_restart,
    output logic       sys_reset,
    output logic       fault,
    output logic [3:0] strikes
);

    localparam int CNT_MAX = (RST_CYCLES > HOLDOFF) ? RST_CYCLES : HOLDOFF;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
    localparam logic [3:0]    STRIKE_LIMIT = 4'(MAX_STRIKES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_RST_HOLD = 3'd2,
        S_HOLDOFF  = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    next_strikes;

    // Strike count after one more expiry, saturating at the escalation limit
    always_comb begin
        next_strikes = strikes;
        if (strikes >= STRIKE_LIMIT) begin
            next_strikes = strikes;
        end else begin
            next_strikes = strikes + 4'd1;
        end
    end

    // Supervisor FSM; every output is registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= {CW{1'b0}};
            wd_enable  <= 1'b0;
            wd_restart <= 1'b0;
            sys_reset  <= 1'b0;
            fault      <= 1'b0;
            strikes    <= 4'd0;
        end else begin
            wd_restart <= 1'b0;
            case (state)
                S_IDLE: begin
                    sys_reset <= 1'b0;
                    fault     <= 1'b0;
                    if (arm) begin
                        state     <= S_ARMED;
                        cnt       <= {CW{1'b0}};
                        wd_enable <= 1'b1;
                    end else begin
                        wd_enable <= 1'b0;
                    end
                end
                S_ARMED: begin
                    // Timeout outranks disarm, which outranks a heartbeat
                    if (timeout) begin
                        strikes   <= next_strikes;
                        wd_enable <= 1'b0;
                        sys_reset <= 1'b1;
                        if (next_strikes == STRIKE_LIMIT) begin
                            state <= S_FAULT;
                            cnt   <= {CW{1'b0}};
                            fault <= 1'b1;
                        end else begin
                            state <= S_RST_HOLD;
                            cnt   <= RST_LOAD;
                        end
                    end else if (!arm) begin
                        state     <= S_IDLE;
                        cnt       <= {CW{1'b0}};
                        wd_enable <= 1'b0;
                    end else begin
                        wd_enable  <= 1'b1;
                        wd_restart <= heartbeat;
                        if (heartbeat) begin
                            strikes <= 4'd0;
                        end else begin
                            strikes <= strikes;
                        end
                    end
                end
                S_RST_HOLD: begin
                    if (cnt == {CW{1'b0}}) begin
                        state     <= S_HOLDOFF;
                        cnt       <= HOLD_LOAD;
                        sys_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == {CW{1'b0}}) begin
                        if (arm) begin
                            state     <= S_ARMED;
                            wd_enable <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FAULT: begin
                    if (fault_clear) begin
                        state     <= S_IDLE;
                        sys_reset <= 1'b0;
                        fault     <= 1'b0;
                        strikes   <= 4'd0;
                    end else begin
                        sys_reset <= 1'b1;
                        fault     <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    cnt        <= {CW{1'b0}};
                    wd_enable  <= 1'b0;
                    sys_reset  <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed bench for watchdog_supervisor: stimulus pushes hand-computed expected outputs
// into a queue; a monitor on the falling edge pops and compares them.
module tb_watchdog_supervisor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arm = 1'b0;
    logic       heartbeat = 1'b0;
    logic       fault_clear = 1'b0;
    logic       timeout = 1'b0;
    logic       wd_enable;
    logic       wd_restart;
    logic       sys_reset;
    logic       fault;
    logic [3:0] strikes;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    watchdog_supervisor #(.RST_CYCLES(8), .HOLDOFF(4), .MAX_STRIKES(3)) dut (
        .clk(clk), .reset(reset), .arm(arm), .heartbeat(heartbeat),
        .fault_clear(fault_clear), .timeout(timeout), .wd_enable(wd_enable),
        .wd_restart(wd_restart), .sys_reset(sys_reset), .fault(fault), .strikes(strikes)
    );

    always #5 clk = ~clk;

    // Packed expectation: {wd_enable, wd_restart, sys_reset, fault, strikes}
    function automatic logic [7:0] e(input logic en, input logic rs, input logic sr,
                                     input logic f, input logic [3:0] st);
        return {en, rs, sr, f, st};
    endfunction

    // Drive one cycle of inputs; expected outputs are those after the sampling edge
    task automatic step(input logic a, input logic hb, input logic to, input logic fc,
                        input logic rst, input logic [7:0] exp_v, input string nm);
        arm = a; heartbeat = hb; timeout = to; fault_clear = fc; reset = rst;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
    endtask

    // One non-escalating expiry: 8 cycles of sys_reset, 4 quiet cycles, then re-arm decision
    task automatic expire(input logic hb, input logic arm_at_to, input logic arm_after,
                          input logic [3:0] s, input string nm);
        step(arm_at_to, hb, 1'b1, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b0, s), {nm, "_enter"});
        for (int i = 0; i < 7; i++)
            step(arm_after, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b0, s), {nm, "_rsthold"});
        for (int i = 0; i < 4; i++)
            step(arm_after, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, s), {nm, "_holdoff"});
        step(arm_after, 1'b0, 1'b0, 1'b0, 1'b0, e(arm_after, 1'b0, 1'b0, 1'b0, s), {nm, "_rearm"});
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] exp_v;
            logic [7:0] act_v;
            string      nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {wd_enable, wd_restart, sys_reset, fault, strikes};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL %s: got en=%b rs=%b sr=%b f=%b st=%0d, expected en=%b rs=%b sr=%b f=%b st=%0d",
                         nm, act_v[7], act_v[6], act_v[5], act_v[4], act_v[3:0],
                         exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
            end
        end
    end

    initial begin
        // Reset then arm with periodic heartbeats
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset0");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "idle_ignores");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "arm_enable");
        for (int i = 0; i < 200; i++)
            step(1'b1, (i % 10) == 0, 1'b0, 1'b0, 1'b0,
                 e(1'b1, (i % 10) == 0, 1'b0, 1'b0, 4'd0), "heartbeat_run");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "hb_b2b_0");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "hb_b2b_1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "fc_in_armed");

        // Single expiry, then a heartbeat clears the strike
        expire(1'b0, 1'b1, 1'b1, 4'd1, "single");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd1), "strike_kept");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "hb_clears");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "kick_one_cycle");

        // Escalation to FAULT on the third consecutive expiry
        expire(1'b0, 1'b1, 1'b1, 4'd1, "esc1");
        expire(1'b0, 1'b1, 1'b1, 4'd2, "esc2");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b1, 4'd3), "fault_enter");
        for (int i = 0; i < 50; i++)
            step(i[0], i[1], i[2], 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b1, 4'd3), "fault_hold");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "fault_clear");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "idle_after_clear");

        // Simultaneous heartbeat+timeout, then timeout with arm low and disarm in holdoff
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "rearm");
        expire(1'b1, 1'b1, 1'b1, 4'd1, "hb_and_to");
        expire(1'b0, 1'b0, 1'b0, 4'd2, "disarm_to");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd2), "idle_stays");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd2), "rearm_keeps_strikes");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "hb_clears2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "disarm_beats_hb");

        // Reset on cycle 3 of RST_HOLD
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "arm_again");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "mid_to");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "mid_hold2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "mid_hold3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset_mid_hold");

        // Reset during FAULT
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "arm_for_fault");
        expire(1'b0, 1'b1, 1'b1, 4'd1, "rf1");
        expire(1'b0, 1'b1, 1'b1, 4'd2, "rf2");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b1, 4'd3), "rf_fault");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0, 1'b0, 1'b1, 1'b1, 4'd3), "rf_fault_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset_in_fault");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "arm_after_reset");

        // Let the monitor drain pending expectations, within a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
